// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcodes, flag bit positions
// and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// prod is the accumulator value the current step produces.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign busy = (cnt != '0);
  assign done = busy && (cnt == CW'(1));
  assign prod = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, status flags
// and a multi-cycle multiply; one operation in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] WV = WIDTH[WIDTH-1:0];

  state_e             state;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_r;
  logic [3:0]         alu_f;
  logic [WIDTH-1:0]   ld_r;
  logic [3:0]         ld_f;
  logic               load;

  assign in_ready  = (state == S_IDLE) && !mul_busy
                     && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e'(op) == OP_MUL);
  assign load      = (accept && !mul_start) || mul_done;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    ext   = '0;
    alu_r = '0;
    alu_f = '0;
    unique case (op_e'(op))
      OP_ADD: begin
        ext          = {1'b0, a} + {1'b0, b};
        alu_r        = ext[WIDTH-1:0];
        alu_f[FLAG_C] = ext[WIDTH];
        alu_f[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1])
                        && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext          = {1'b0, a} - {1'b0, b};
        alu_r        = ext[WIDTH-1:0];
        alu_f[FLAG_C] = ext[WIDTH];
        alu_f[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1])
                        && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_XOR: alu_r = a ^ b;
      OP_OR:  alu_r = a | b;
      OP_SHL: alu_r = (b >= WV) ? '0 : (a << b);
      OP_SHR: alu_r = (b >= WV) ? '0 : (a >> b);
      OP_MUL: alu_r = '0;
    endcase
  end

  // Multiply completion reuses the same flag rules as the one-cycle ops.
  always_comb begin
    ld_r = mul_done ? mul_prod[WIDTH-1:0] : alu_r;
    ld_f = mul_done ? 4'h0 : alu_f;
    if (mul_done)
      ld_f[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    ld_f[FLAG_N] = ld_r[WIDTH-1];
    ld_f[FLAG_Z] = (ld_r == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (mul_start) state <= S_MUL;
        S_MUL:  if (mul_done)  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= ld_r;
      flags     <= ld_f;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic
// reference model, WIDTH=8.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {V,N,Z,C, result}
  function automatic logic [11:0] model(input logic [2:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    int xu, yu, xs, ys, t, r;
    bit c, v;
    xu = x; yu = y;
    xs = (xu > 127) ? xu - 256 : xu;
    ys = (yu > 127) ? yu - 256 : yu;
    c = 0; v = 0; r = 0;
    case (o)
      3'd0: begin
        t = xu + yu; r = t % 256; c = (t > 255);
        v = (xs + ys > 127) || (xs + ys < -128);
      end
      3'd1: begin
        r = (xu - yu + 256) % 256; c = (xu < yu);
        v = (xs - ys > 127) || (xs - ys < -128);
      end
      3'd2: r = xu & yu;
      3'd3: r = xu ^ yu;
      3'd4: r = xu | yu;
      3'd5: r = (yu >= 8) ? 0 : (xu * (1 << yu)) % 256;
      3'd6: r = (yu >= 8) ? 0 : xu / (1 << yu);
      default: begin
        t = xu * yu; r = t % 256; c = (t > 255);
      end
    endcase
    return {v, (r >= 128), (r == 0), c, 8'(r)};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y);
    logic [11:0] e;
    int nz;
    e = model(o, x, y);
    nz = (o == 3'd7) ? W : 0;
    @(negedge clk);
    op = o; a = x; b = y;
    in_valid = 1'b1; out_ready = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    for (int i = 0; i < nz; i++) begin
      @(negedge clk);
      chk("mul_wait_valid", out_valid, 0);
      chk("mul_wait_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk($sformatf("result op%0d %h,%h", o, x, y), result, e[7:0]);
    chk($sformatf("flags op%0d %h,%h", o, x, y), flags, e[11:8]);
  endtask

  initial begin
    logic [7:0] hr;
    logic [3:0] hf;
    logic [11:0] e;
    logic [2:0] ro;
    logic [7:0] rx, ry;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 8'hF0, 8'h20);
    chk("add_dir_flags", flags, 4'b0001);
    run_op(3'd1, 8'h7F, 8'hFF);
    chk("sub_dir_flags", flags, 4'b1101);
    run_op(3'd5, 8'h81, 8'd3);
    chk("shl3", result, 8'h08);
    run_op(3'd5, 8'h81, 8'd9);
    chk("shl9_z", flags[1], 1);
    run_op(3'd6, 8'h80, 8'd7);
    chk("shr7", result, 8'h01);
    run_op(3'd7, 8'h0F, 8'h11);
    chk("mul_ff", {flags[0], result}, 9'h0FF);
    run_op(3'd7, 8'h10, 8'h10);
    chk("mul_zc", flags, 4'b0011);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      rx = 8'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12))
                                        : 8'($urandom);
      run_op(ro, rx, ry);
    end

    // backpressure: hold an ADD result, queue an XOR behind it
    @(negedge clk);
    op = 3'd0; a = 8'hF0; b = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    hr = result; hf = flags;
    chk("bp_first", result, 8'h10);
    op = 3'd3; a = 8'h5A; b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, hr);
      chk("bp_flags", flags, hf);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", in_ready, 1);
    e = model(3'd3, 8'h5A, 8'hFF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_result", result, e[7:0]);
    chk("bp_next_flags", flags, e[11:8]);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // reset in the middle of a multiply
    run_op(3'd1, 8'h00, 8'h01);
    @(negedge clk);
    op = 3'd7; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_flags", flags, 0);
    chk("mrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mrst_no_valid", out_valid, 0);
      chk("mrst_ready_after", in_ready, 1);
    end

    run_op(3'd7, 8'h03, 8'h05);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
